swbtn_conditioner: RTL and testbench
====================================

SWBTN_CONDITIONER -- requirements
Module: swbtn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of cycles (10 ms at 50 MHz) an input must hold a new level before it is accepted.
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the number of cycles from a press pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 5000000, is the number of cycles between subsequent auto-repeat pulses.
REQ-004 clk  input  1  system clock, 50 MHz, the same clock as the VGA sprite component.
REQ-005 reset  input  1  reset; asynchronous and active-high.
REQ-006 sw  input  10  raw, asynchronous slide switches.
REQ-007 key  input  4  raw, asynchronous push buttons; active-low (0 = pressed).
REQ-008 switchbuttons  output  16  conditioned vector feeding the sprite component's switchbuttons input.
REQ-009 btn_press  output  4  one-cycle press strobes, one bit per button.

Function
REQ-010 Each of the 14 inputs SHALL pass through a 2-flop synchronizer; key bits SHALL be inverted after synchronization so that 1 = pressed.
REQ-011 Each bit SHALL keep a stable register and a counter: the counter increments while the synced value differs from stable, and clears to 0 whenever they are equal.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 while the values still differ, stable SHALL take the synced value and the counter SHALL clear.
REQ-013 Latency from a clean input edge to the output change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never reach the output.
REQ-015 switchbuttons[9:0] SHALL carry stable sw, and switchbuttons[13:10] SHALL carry stable pressed buttons.
REQ-016 switchbuttons[14] (changed) SHALL pulse for one cycle in any cycle where at least one stable bit changes while valid=1.
REQ-017 switchbuttons[15] (valid) SHALL be 0 from reset until a startup counter reaches DEBOUNCE_CYCLES+2 cycles, then 1 until the next reset.
REQ-018 btn_press[i] SHALL pulse for one cycle on each 0->1 change of the stable value of button i while valid=1.
REQ-019 Stable changes during valid=0 SHALL still update switchbuttons[13:0] but SHALL generate no btn_press or changed pulses.
REQ-020 Simultaneous changes on several bits SHALL each be processed independently, and SHALL produce a single changed pulse per cycle.
REQ-021 Counter widths SHALL be $clog2 of the corresponding parameter plus 1; no counter SHALL wrap, and each saturates or clears as specified above.

Reset
REQ-022 While reset=1, all synchronizer flops, stable registers and counters SHALL be 0, and switchbuttons and btn_press SHALL be 16'h0000 and 4'h0.
REQ-023 Reset asserted mid-debounce or mid-repeat SHALL abandon the operation with no pulse emitted; operation SHALL restart from REQ-017 on deassertion.

Configuration
REQ-024 The macro SWBTN_AUTOREPEAT_EN SHALL compile in auto-repeat.
REQ-025 With SWBTN_AUTOREPEAT_EN defined, a held button i SHALL pulse btn_press[i] REPEAT_DELAY cycles after its press pulse and then every REPEAT_PERIOD cycles while held.
REQ-026 With auto-repeat compiled in, release SHALL clear that button's repeat counter immediately.
REQ-027 With auto-repeat compiled in, each button SHALL have an independent repeat counter.
REQ-028 Without SWBTN_AUTOREPEAT_EN, repeat logic SHALL be absent, giving exactly one btn_press pulse per press.

Structure
REQ-029 Package swbtn_pkg SHALL hold the NUM_SW=10, NUM_KEY=4 and bit-index constants (CHANGED_BIT=14, VALID_BIT=15).
REQ-030 A single sub-module, debounce_cell (synchronizer, counter and stable register for one bit, with parameter DEBOUNCE_CYCLES), SHALL be instantiated 14 times.

Verification (benches use DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6)
REQ-031 Reset release with sw=10'h2A5 and key=4'hF -> valid rises 10 cycles later, switchbuttons=16'h82A5, and there are no btn_press or changed pulses.
REQ-032 key[2] held low for 5 cycles then high -> switchbuttons unchanged and no btn_press.
REQ-033 key[1] held low steadily -> switchbuttons[11]=1 exactly 10 cycles later, with btn_press=4'b0010 and changed=1 in that same single cycle.
REQ-034 sw[0] and sw[9] toggled in the same cycle -> both output bits change in the same cycle, with exactly one changed pulse.
REQ-035 reset asserted 4 cycles into a key[0] debounce -> all outputs 0 immediately; after release, valid behaves as in REQ-031.
REQ-036 With SWBTN_AUTOREPEAT_EN, key[3] held for 60 cycles after acceptance -> btn_press[3] pulses at offsets 0, 20, 26, 32, 38, 44, 50 and 56, and stops on release.

Source files
------------

// File: rtl/swbtn_pkg.sv
// Shared constants for the switch/button conditioner: input counts and the
// positions of the status bits inside the switchbuttons vector.
package swbtn_pkg;
  localparam int NUM_SW      = 10;
  localparam int NUM_KEY     = 4;
  localparam int NUM_IN      = NUM_SW + NUM_KEY;
  localparam int KEY_BASE    = NUM_SW;
  localparam int CHANGED_BIT = 14;
  localparam int VALID_BIT   = 15;
endpackage

// File: rtl/debounce_cell.sv
// One conditioned input: 2-flop synchronizer, optional post-sync inversion,
// and a hold counter that promotes the synced level into the stable register.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic update
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          synced;
  logic          stable_q;
  logic [CW-1:0] cnt;

  assign synced = INVERT ? ~sync2 : sync2;
  // update is high in the single cycle the stable register is about to flip
  assign update = (synced != stable_q) && (cnt == CNT_LAST);
  assign stable = stable_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (synced == stable_q) begin
        cnt <= '0;
      end else if (update) begin
        stable_q <= synced;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/swbtn_conditioner.sv
// Debounces 10 switches and 4 active-low keys into the sprite switchbuttons
// vector plus press strobes. Define SWBTN_AUTOREPEAT_EN to add key auto-repeat.
module swbtn_conditioner
  import swbtn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_KEY-1:0] key,
  output logic [15:0]        switchbuttons,
  output logic [NUM_KEY-1:0] btn_press
);
  localparam int SU_W = $clog2(DEBOUNCE_CYCLES + 2) + 1;
  localparam logic [SU_W-1:0] SU_DONE = SU_W'(DEBOUNCE_CYCLES + 2);

  logic [NUM_IN-1:0]  raw;
  logic [NUM_IN-1:0]  stable;
  logic [NUM_IN-1:0]  upd;
  logic [NUM_KEY-1:0] rise;
  logic [NUM_KEY-1:0] rep_fire;
  logic [NUM_KEY-1:0] press_q;
  logic [SU_W-1:0]    su_cnt;
  logic               valid;
  logic               changed_q;

  assign raw = {key, sw};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         ((g >= NUM_SW) ? 1'b1 : 1'b0)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .din   (raw[g]),
      .stable(stable[g]),
      .update(upd[g])
    );
  end

  // Outputs are untrusted until every cell has had one full debounce window.
  assign valid = (su_cnt == SU_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      su_cnt <= '0;
    end else if (!valid) begin
      su_cnt <= su_cnt + 1'b1;
    end
  end

  assign rise = upd[KEY_BASE +: NUM_KEY] & ~stable[KEY_BASE +: NUM_KEY];

`ifdef SWBTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX) + 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [NUM_KEY-1:0] held_next;

  // Use the post-edge level so a release clears the counter in its own cycle.
  assign held_next = stable[KEY_BASE +: NUM_KEY] ^ upd[KEY_BASE +: NUM_KEY];

  for (genvar k = 0; k < NUM_KEY; k++) begin : g_rep
    logic [REP_W-1:0] rep_cnt;
    logic             rep_phase;

    assign rep_fire[k] = valid && held_next[k] && !rise[k] &&
                         (rep_cnt == (rep_phase ? PERIOD_LAST : DELAY_LAST));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
      end else if (!held_next[k] || rise[k]) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
      end else if (rep_fire[k]) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b1;
      end else if (valid) begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      changed_q <= 1'b0;
      press_q   <= '0;
    end else begin
      changed_q <= valid && (|upd);
      press_q   <= (valid ? rise : '0) | rep_fire;
    end
  end

  always_comb begin
    switchbuttons              = '0;
    switchbuttons[NUM_IN-1:0]  = stable;
    switchbuttons[CHANGED_BIT] = changed_q;
    switchbuttons[VALID_BIT]   = valid;
  end

  assign btn_press = press_q;
endmodule

// File: tb/tb_swbtn_conditioner.sv
// Directed and random checks of swbtn_conditioner against a sliding-window
// reference model of debounce, startup-valid, strobes and auto-repeat.
module tb_swbtn_conditioner;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [15:0] switchbuttons;
  logic [3:0]  btn_press;

  int total = 0;
  int bad   = 0;

  logic [19:0] exp_q[$];
  logic [13:0] hist[$];
  logic [13:0] m_stable;
  int          m_since;
  int          age[4];

  swbtn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .key          (key),
    .switchbuttons(switchbuttons),
    .btn_press    (btn_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reset leaves synchronizers at 0, which reads as "pressed" on the key lanes.
  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back({4'hF, 10'h000});
    m_stable = '0;
    m_since  = 0;
    for (int k = 0; k < 4; k++) age[k] = 0;
  endtask

  // A bit flips when its last D synchronized samples all oppose the stable
  // level and at least D clock edges have elapsed since reset release.
  task automatic model_edge();
    logic [13:0] flips;
    logic [13:0] nxt;
    logic [13:0] h;
    logic [3:0]  press;
    logic        vb;
    logic        chg;
    int          n;
    hist.push_back({~key, sw});
    n = hist.size();
    flips = '0;
    if (m_since + 1 >= D) begin
      for (int b = 0; b < 14; b++) begin
        flips[b] = 1'b1;
        for (int j = n - 2 - D; j <= n - 3; j++) begin
          h = hist[j];
          if (h[b] == m_stable[b]) flips[b] = 1'b0;
        end
      end
    end
    vb    = (m_since >= D + 2);
    nxt   = m_stable ^ flips;
    press = vb ? (flips[13:10] & nxt[13:10]) : 4'h0;
    chg   = vb && (|flips);
`ifdef SWBTN_AUTOREPEAT_EN
    for (int k = 0; k < 4; k++) begin
      if (!nxt[10+k] || flips[10+k]) age[k] = 0;
      else if (vb) begin
        age[k]++;
        if (age[k] == RD || (age[k] > RD && (age[k] - RD) % RP == 0)) press[k] = 1'b1;
      end
    end
`endif
    m_stable = nxt;
    if (m_since < D + 2) m_since++;
    exp_q.push_back({(m_since >= D + 2), chg, nxt, press});
    while (hist.size() > D + 4) void'(hist.pop_front());
  endtask

  task automatic step();
    logic [19:0] e;
    @(posedge clk);
    if (reset) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      model_edge();
    end
    #1;
    e = exp_q.pop_front();
    check("model", {12'h0, switchbuttons, btn_press}, {12'h0, e});
  endtask

  initial begin
    logic [3:0] seen;
    int         offs[$];
    int         exp_offs[8];
    exp_offs = '{0, 20, 26, 32, 38, 44, 50, 56};

    // Reset with switches preset and keys released.
    reset = 1'b1;
    sw    = 10'h2A5;
    key   = 4'hF;
    model_reset();
    #1;
    check("reset_sb", {16'h0, switchbuttons}, 32'h0);
    check("reset_press", {28'h0, btn_press}, 32'h0);
    repeat (3) step();

    // Startup: valid rises on the 10th edge together with the switch image.
    reset = 1'b0;
    seen  = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      seen |= btn_press;
      if (i == 9) check("valid_early", {31'h0, switchbuttons[15]}, 32'h0);
      if (i == 10) check("startup_sb", {16'h0, switchbuttons}, 32'h82A5);
    end
    check("startup_press", {28'h0, seen}, 32'h0);
    repeat (5) step();

    // Short glitch on key[2] is filtered.
    key[2] = 1'b0;
    repeat (5) step();
    key[2] = 1'b1;
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen |= btn_press;
    end
    check("glitch_sb", {16'h0, switchbuttons}, 32'h82A5);
    check("glitch_press", {28'h0, seen}, 32'h0);

    // Clean press of key[1]: accepted on the 10th edge with one strobe.
    key[1] = 1'b0;
    repeat (9) step();
    check("press_pre", {31'h0, switchbuttons[11]}, 32'h0);
    step();
    check("press_level", {31'h0, switchbuttons[11]}, 32'h1);
    check("press_strobe", {28'h0, btn_press}, 32'h2);
    check("press_changed", {31'h0, switchbuttons[14]}, 32'h1);
    step();
    check("press_one_cycle", {28'h0, btn_press}, 32'h0);
    check("changed_one_cycle", {31'h0, switchbuttons[14]}, 32'h0);
    key[1] = 1'b1;
    repeat (15) step();

    // Two switches toggled together land together with one changed pulse.
    sw = sw ^ 10'h201;
    repeat (9) step();
    check("dual_pre", {22'h0, switchbuttons[9:0]}, 32'h2A5);
    step();
    check("dual_sw", {22'h0, switchbuttons[9:0]}, 32'h0A4);
    check("dual_changed", {31'h0, switchbuttons[14]}, 32'h1);
    step();
    check("dual_changed_once", {31'h0, switchbuttons[14]}, 32'h0);

    // Random toggles and glitches on all 14 inputs.
    for (int r = 0; r < 60; r++) begin
      int b;
      int hold;
      b    = $urandom_range(0, 13);
      hold = $urandom_range(1, 14);
      if (b < 10) sw[b] = ~sw[b];
      else key[b-10] = ~key[b-10];
      repeat (hold) step();
    end
    key = 4'hF;
    repeat (20) step();

    // Reset in the middle of a key[0] debounce.
    key[0] = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #1;
    model_reset();
    check("midreset_sb", {16'h0, switchbuttons}, 32'h0);
    check("midreset_press", {28'h0, btn_press}, 32'h0);
    repeat (3) step();
    key   = 4'hF;
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9) check("revalid_early", {31'h0, switchbuttons[15]}, 32'h0);
      if (i == 10) check("revalid", {31'h0, switchbuttons[15]}, 32'h1);
    end
    repeat (5) step();

`ifdef SWBTN_AUTOREPEAT_EN
    // Hold key[3] for 60 cycles after acceptance, then release.
    key[3] = 1'b0;
    for (int t = -9; t <= 80; t++) begin
      step();
      if (btn_press[3]) offs.push_back(t);
      if (t == 50) key[3] = 1'b1;
    end
    check("rep_count", offs.size(), 8);
    for (int i = 0; i < 8; i++)
      check("rep_offset", (i < offs.size()) ? offs[i] : -1, exp_offs[i]);
`else
    // Without auto-repeat a long hold yields exactly one strobe.
    key[3] = 1'b0;
    for (int t = -9; t <= 80; t++) begin
      step();
      if (btn_press[3]) offs.push_back(t);
      if (t == 50) key[3] = 1'b1;
    end
    check("single_count", offs.size(), 1);
    check("single_offset", (offs.size() > 0) ? offs[0] : -1, exp_offs[0]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
